// File: rtl/maze_pkg.sv
// ============================================================================
// Module : maze_pkg
// Brief  : Shared maze geometry, path layout and writer FSM encodings.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package maze_pkg;

    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 7;
    localparam int CELLS  = ROWS * COLS;
    localparam int ADDR_W = 6;
    localparam int CELL_W = 7;

    // Bit index is row*COLS+col, so each row byte holds col 0 in its LSB.
    localparam logic [CELLS-1:0] PATH_MAP = {
        8'h00,  // row 7
        8'h7E,  // row 6
        8'h42,  // row 5
        8'h42,  // row 4
        8'h7E,  // row 3
        8'h12,  // row 2
        8'h1E,  // row 1
        8'h00   // row 0
    };

    localparam logic [CNT_W-1:0] PELLET_INIT_CNT = 7'd22;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_RELOAD = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/maze_cell_index.sv
// ============================================================================
// Module : maze_cell_index
// Brief  : Maps (row,col) to a row-major cell index with an in-range flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module maze_cell_index #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int IDX_W  = 3,
    parameter int ADDR_W = 6
) (
    input  logic [IDX_W-1:0]  i_row,
    input  logic [IDX_W-1:0]  i_col,
    output logic [ADDR_W-1:0] o_idx,
    output logic              o_in_range
);

    assign o_idx      = ADDR_W'(i_row) * ADDR_W'(COLS) + ADDR_W'(i_col);
    assign o_in_range = (32'(i_row) < ROWS) && (32'(i_col) < COLS);

endmodule

`default_nettype wire

// File: rtl/maze_pellet_writer.sv
// ============================================================================
// Module : maze_pellet_writer
// Brief  : Writable 8x8 pellet map with req/ack writes, reload FSM and read port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module maze_pellet_writer #(
    parameter int ROWS  = maze_pkg::ROWS,
    parameter int COLS  = maze_pkg::COLS,
    parameter int IDX_W = maze_pkg::IDX_W,
    parameter int CNT_W = maze_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_req,
    input  logic [IDX_W-1:0] wr_row,
    input  logic [IDX_W-1:0] wr_col,
    input  logic             wr_val,
    output logic             wr_ack,
    input  logic             reload_req,
    output logic             busy,
    input  logic [IDX_W-1:0] rd_row,
    input  logic [IDX_W-1:0] rd_col,
    output logic             rd_path,
    output logic             rd_pellet,
    output logic [CNT_W-1:0] pellet_cnt,
    output logic             all_clear
);

    import maze_pkg::*;

    localparam int N_CELLS = ROWS * COLS;

    state_t              r_state;
    logic [IDX_W-1:0]    r_wr_row;
    logic [IDX_W-1:0]    r_wr_col;
    logic                r_wr_val;
    logic [N_CELLS-1:0]  r_pellet;
    logic [CELL_W-1:0]   r_reload_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_wr_ack;
    logic                r_busy;
    logic                r_rd_path;
    logic                r_rd_pellet;
    logic                r_all_clear;

    logic [ADDR_W-1:0]   w_wr_addr;
    logic                w_wr_in_range;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_rd_in_range;
    logic [ADDR_W-1:0]   w_rl_addr;

    maze_cell_index #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .IDX_W  (IDX_W),
        .ADDR_W (ADDR_W)
    ) u_wr_index (
        .i_row      (r_wr_row),
        .i_col      (r_wr_col),
        .o_idx      (w_wr_addr),
        .o_in_range (w_wr_in_range)
    );

    maze_cell_index #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .IDX_W  (IDX_W),
        .ADDR_W (ADDR_W)
    ) u_rd_index (
        .i_row      (rd_row),
        .i_col      (rd_col),
        .o_idx      (w_rd_addr),
        .o_in_range (w_rd_in_range)
    );

    assign w_rl_addr = r_reload_idx[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wr_row     <= '0;
            r_wr_col     <= '0;
            r_wr_val     <= 1'b0;
            r_pellet     <= PATH_MAP;
            r_reload_idx <= '0;
            r_cnt        <= CNT_W'(PELLET_INIT_CNT);
            r_wr_ack     <= 1'b0;
            r_busy       <= 1'b0;
            r_rd_path    <= 1'b0;
            r_rd_pellet  <= 1'b0;
            r_all_clear  <= 1'b0;
        end else begin
            r_wr_ack    <= 1'b0;
            // Non-blocking reads here see the pre-write contents of the map.
            r_rd_path   <= w_rd_in_range && PATH_MAP[w_rd_addr];
            r_rd_pellet <= w_rd_in_range && r_pellet[w_rd_addr];
            r_all_clear <= (r_cnt == '0) && !r_busy;

            case (r_state)
                ST_IDLE: begin
                    if (reload_req) begin
                        r_state      <= ST_RELOAD;
                        r_busy       <= 1'b1;
                        r_cnt        <= '0;
                        r_reload_idx <= '0;
                    end else if (wr_req) begin
                        r_state  <= ST_WRITE;
                        r_wr_row <= wr_row;
                        r_wr_col <= wr_col;
                        r_wr_val <= wr_val;
                        r_wr_ack <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    // Only a real bit flip moves the counter, so it cannot wrap.
                    if (w_wr_in_range && PATH_MAP[w_wr_addr]) begin
                        if (!r_wr_val && r_pellet[w_wr_addr]) begin
                            r_pellet[w_wr_addr] <= 1'b0;
                            r_cnt               <= r_cnt - CNT_W'(1);
                        end else if (r_wr_val && !r_pellet[w_wr_addr]) begin
                            r_pellet[w_wr_addr] <= 1'b1;
                            r_cnt               <= r_cnt + CNT_W'(1);
                        end
                    end
                    r_state <= ST_IDLE;
                end
                ST_RELOAD: begin
                    r_pellet[w_rl_addr] <= PATH_MAP[w_rl_addr];
                    if (PATH_MAP[w_rl_addr]) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (r_reload_idx == CELL_W'(N_CELLS - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_reload_idx <= r_reload_idx + CELL_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_ack     = r_wr_ack;
    assign busy       = r_busy;
    assign rd_path    = r_rd_path;
    assign rd_pellet  = r_rd_pellet;
    assign pellet_cnt = r_cnt;
    assign all_clear  = r_all_clear;

endmodule

`default_nettype wire

// File: tb/tb_maze_pellet_writer.sv
// ============================================================================
// Module : tb_maze_pellet_writer
// Brief  : Directed self-checking bench for maze_pellet_writer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_maze_pellet_writer;

    logic       clk;
    logic       rst;
    logic       wr_req;
    logic [2:0] wr_row;
    logic [2:0] wr_col;
    logic       wr_val;
    logic       wr_ack;
    logic       reload_req;
    logic       busy;
    logic [2:0] rd_row;
    logic [2:0] rd_col;
    logic       rd_path;
    logic       rd_pellet;
    logic [6:0] pellet_cnt;
    logic       all_clear;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference layout, written as in the maze drawing: leftmost char is col 0.
    logic [7:0] tb_rows [8] = '{
        8'b00000000, 8'b01111000, 8'b01001000, 8'b01111110,
        8'b01000010, 8'b01000010, 8'b01111110, 8'b00000000
    };

    maze_pellet_writer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_val     (wr_val),
        .wr_ack     (wr_ack),
        .reload_req (reload_req),
        .busy       (busy),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_path    (rd_path),
        .rd_pellet  (rd_pellet),
        .pellet_cnt (pellet_cnt),
        .all_clear  (all_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic mpath(input int r, input int c);
        logic [7:0] row_bits;
        row_bits = tb_rows[r];
        return row_bits[7-c];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic read_cell(input int r, input int c, input logic ep, input logic epel, input string tag);
        rd_row = 3'(r);
        rd_col = 3'(c);
        @(negedge clk);
        check({tag, "_path"}, 32'(rd_path), 32'(ep));
        check({tag, "_pellet"}, 32'(rd_pellet), 32'(epel));
    endtask

    // Holds wr_req until ack (bounded), checks ack latency, then lets the update settle.
    task automatic do_write(input int r, input int c, input logic v, input string tag);
        int lat;
        wr_row = 3'(r);
        wr_col = 3'(c);
        wr_val = v;
        wr_req = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (wr_ack) break;
        end
        wr_req = 1'b0;
        if (!wr_ack) lat = 99;
        check({tag, "_ack_lat"}, 32'(lat), 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int busy_cycles;
        int ack_in_busy;
        int acked;

        rst        = 1'b1;
        wr_req     = 1'b0;
        wr_row     = '0;
        wr_col     = '0;
        wr_val     = 1'b0;
        reload_req = 1'b0;
        rd_row     = '0;
        rd_col     = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_wr_ack", 32'(wr_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_path", 32'(rd_path), 32'd0);
        check("rst_rd_pellet", 32'(rd_pellet), 32'd0);
        check("rst_all_clear", 32'(all_clear), 32'd0);
        check("rst_cnt", 32'(pellet_cnt), 32'd22);
        rst = 1'b0;
        @(negedge clk);

        read_cell(1, 1, 1'b1, 1'b1, "rd_1_1");
        read_cell(0, 0, 1'b0, 1'b0, "rd_0_0");
        check("idle_busy", 32'(busy), 32'd0);

        do_write(3, 2, 1'b0, "clr_3_2");
        check("clr_3_2_cnt", 32'(pellet_cnt), 32'd21);
        do_write(3, 2, 1'b0, "clr_3_2_again");
        check("clr_3_2_again_cnt", 32'(pellet_cnt), 32'd21);
        read_cell(3, 2, 1'b1, 1'b0, "rd_3_2");

        do_write(0, 0, 1'b1, "set_wall");
        check("set_wall_cnt", 32'(pellet_cnt), 32'd21);
        read_cell(0, 0, 1'b0, 1'b0, "rd_wall");
        do_write(3, 2, 1'b1, "set_3_2");
        check("set_3_2_cnt", 32'(pellet_cnt), 32'd22);
        do_write(3, 2, 1'b1, "set_full");
        check("set_full_cnt", 32'(pellet_cnt), 32'd22);

        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                do_write(r, c, 1'b0, "clr_all");
            end
        end
        check("clr_all_cnt", 32'(pellet_cnt), 32'd0);
        check("clr_all_flag", 32'(all_clear), 32'd1);
        do_write(1, 1, 1'b0, "clr_empty");
        check("clr_empty_cnt", 32'(pellet_cnt), 32'd0);

        // Reload and write together: reload wins, write is served afterwards.
        wr_row = 3'd3;
        wr_col = 3'd2;
        wr_val = 1'b0;
        wr_req = 1'b1;
        reload_req = 1'b1;
        busy_cycles = 0;
        ack_in_busy = 0;
        acked = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (busy_cycles == 5) reload_req = 1'b0;
            if (wr_ack && busy) ack_in_busy++;
            if (wr_ack) begin
                acked = 1;
                break;
            end
        end
        reload_req = 1'b0;
        wr_req = 1'b0;
        check("rl_acked", 32'(acked), 32'd1);
        check("rl_busy_cycles", 32'(busy_cycles), 32'd64);
        check("rl_ack_in_busy", 32'(ack_in_busy), 32'd0);
        check("rl_cnt_at_ack", 32'(pellet_cnt), 32'd22);
        @(negedge clk);
        @(negedge clk);
        check("rl_cnt_after_wr", 32'(pellet_cnt), 32'd21);
        check("rl_all_clear", 32'(all_clear), 32'd0);

        // Reset in the middle of a reload.
        reload_req = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            reload_req = 1'b0;
            if (busy) busy_cycles++;
            if (busy_cycles == 30) break;
        end
        check("rl2_reached_30", 32'(busy_cycles), 32'd30);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cnt", 32'(pellet_cnt), 32'd22);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                read_cell(r, c, mpath(r, c), mpath(r, c), "map");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
